// File: rtl/f_fetch_unit.sv
// Instruction-fetch stage: PC register, combinational instruction memory with a
// loader write port, delayed-branch next-PC selection and fetch-fault detection.
module f_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_DEPTH = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        En,
    input  logic [1:0]                  npc_sel,
    input  logic                        branch_cond,
    input  logic [31:0]                 d_instr,
    input  logic [31:0]                 d_pcadd8,
    input  logic [31:0]                 d_rs,
    input  logic                        im_we,
    input  logic [$clog2(IM_DEPTH)-1:0] im_waddr,
    input  logic [31:0]                 im_wdata,
    output logic [31:0]                 F_PC,
    output logic [31:0]                 IF,
    output logic [31:0]                 PCadd8,
    output logic                        pc_exc,
    output logic [31:0]                 fetch_count
);

    localparam int          AW     = $clog2(IM_DEPTH);
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(IM_DEPTH) * 33'd4;

    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JR     = 2'b11
    } npc_sel_e;

    logic [31:0] im [IM_DEPTH];
    logic [31:0] pc_off;
    logic [31:0] d_pc4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] npc;
    logic        in_range;
    logic        aligned;
    logic        unused_bits;

    // Range check is done in 33 bits so a base near the top of the address space cannot wrap.
    assign pc_off   = F_PC - IM_BASE;
    assign in_range = ({1'b0, F_PC} >= {1'b0, IM_BASE}) && ({1'b0, F_PC} < IM_END);
    assign aligned  = (F_PC[1:0] == 2'b00);
    assign pc_exc   = ~(in_range & aligned);
    assign IF       = pc_exc ? 32'h0 : im[pc_off[AW+1:2]];
    assign PCadd8   = F_PC + 32'd8;

    assign d_pc4     = d_pcadd8 - 32'd4;
    assign br_target = d_pc4 + {{14{d_instr[15]}}, d_instr[15:0], 2'b00};
    assign j_target  = {d_pc4[31:28], d_instr[25:0], 2'b00};

    assign unused_bits = ^{pc_off[31:AW+2], pc_off[1:0], d_instr[31:26]};

    // NOTE: every path through always_comb assigns npc (default first), so no latch is inferred.
    always_comb begin
        npc = F_PC + 32'd4;
        unique case (npc_sel_e'(npc_sel))
            NPC_SEQ:    npc = F_PC + 32'd4;
            NPC_BRANCH: npc = branch_cond ? br_target : F_PC + 32'd4;
            NPC_JUMP:   npc = j_target;
            NPC_JR:     npc = d_rs;
            default:    npc = F_PC + 32'd4;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            F_PC        <= PC_RESET;
            fetch_count <= 32'd0;
        end else if (En) begin
            F_PC        <= npc;
            fetch_count <= fetch_count + 32'd1;
        end
    end

    // NOTE: the memory array is deliberately not reset; program contents survive reset.
    always_ff @(posedge clk) begin
        if (im_we) begin
            im[im_waddr] <= im_wdata;
        end
    end

endmodule

// File: tb/tb_f_fetch_unit.sv
// Self-checking bench for f_fetch_unit: directed test-plan steps followed by a
// randomized phase, all compared against a behavioural PC/IM model.
module tb_f_fetch_unit;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam int          IM_DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        En;
    logic [1:0]  npc_sel;
    logic        branch_cond;
    logic [31:0] d_instr;
    logic [31:0] d_pcadd8;
    logic [31:0] d_rs;
    logic        im_we;
    logic [11:0] im_waddr;
    logic [31:0] im_wdata;
    logic [31:0] F_PC;
    logic [31:0] IF;
    logic [31:0] PCadd8;
    logic        pc_exc;
    logic [31:0] fetch_count;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] m_mem [IM_DEPTH];

    f_fetch_unit #(
        .PC_RESET(PC_RESET),
        .IM_BASE (IM_BASE),
        .IM_DEPTH(IM_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .En         (En),
        .npc_sel    (npc_sel),
        .branch_cond(branch_cond),
        .d_instr    (d_instr),
        .d_pcadd8   (d_pcadd8),
        .d_rs       (d_rs),
        .im_we      (im_we),
        .im_waddr   (im_waddr),
        .im_wdata   (im_wdata),
        .F_PC       (F_PC),
        .IF         (IF),
        .PCadd8     (PCadd8),
        .pc_exc     (pc_exc),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic m_fault(input logic [31:0] pc);
        longint unsigned p;
        p = longint'(pc);
        return (pc % 4 != 0) || (p < longint'(IM_BASE)) ||
               (p >= longint'(IM_BASE) + 4 * IM_DEPTH);
    endfunction

    function automatic logic [31:0] m_if(input logic [31:0] pc);
        if (m_fault(pc)) return 32'h0;
        return m_mem[(pc - IM_BASE) / 4];
    endfunction

    // Next PC from the architectural rules, using plain arithmetic.
    function automatic logic [31:0] m_next(input logic [31:0] pc);
        logic [31:0] base;
        shortint     imm;
        base = d_pcadd8 - 32'd4;
        imm  = shortint'(d_instr[15:0]);
        case (npc_sel)
            2'd1:    return branch_cond ? base + 32'(int'(imm) * 4) : pc + 32'd4;
            2'd2:    return (base & 32'hF000_0000) + (d_instr & 32'h03FF_FFFF) * 4;
            2'd3:    return d_rs;
            default: return pc + 32'd4;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".F_PC"},        F_PC,                m_pc);
        check({tag, ".PCadd8"},      PCadd8,              m_pc + 32'd8);
        check({tag, ".pc_exc"},      {31'd0, pc_exc},     {31'd0, m_fault(m_pc)});
        check({tag, ".IF"},          IF,                  m_if(m_pc));
        check({tag, ".fetch_count"}, fetch_count,         m_cnt);
    endtask

    // One rising edge; model absorbs the inputs that were stable across it.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_pc  = PC_RESET;
            m_cnt = 32'd0;
        end else if (En) begin
            m_pc  = m_next(m_pc);
            m_cnt = m_cnt + 32'd1;
        end
        if (im_we) m_mem[im_waddr] = im_wdata;
        #1;
    endtask

    task automatic set_ctl(input logic en, input logic [1:0] sel, input logic bc,
                           input logic [31:0] instr, input logic [31:0] pc8,
                           input logic [31:0] rs);
        En = en; npc_sel = sel; branch_cond = bc;
        d_instr = instr; d_pcadd8 = pc8; d_rs = rs;
    endtask

    initial begin
        logic [31:0] plan [4];
        plan[0] = 32'h1111_1111; plan[1] = 32'h2222_2222;
        plan[2] = 32'h3333_3333; plan[3] = 32'h4444_4444;

        reset = 1'b1;
        set_ctl(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        im_we = 1'b0; im_waddr = '0; im_wdata = '0;
        m_pc = PC_RESET; m_cnt = 32'd0;
        #2;

        // Program load while reset is held: writes must still land.
        for (int i = 0; i < IM_DEPTH; i++) begin
            im_we    = 1'b1;
            im_waddr = 12'(i);
            im_wdata = (i < 4) ? plan[i] : $urandom;
            tick();
        end
        im_we = 1'b0;
        check_all("reset");

        reset = 1'b0;
        #2;
        set_ctl(1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        check_all("seq0");
        tick(); check_all("seq1");

        // Stall at 3004 with a jump presented: must be ignored.
        set_ctl(1'b0, 2'd2, 1'b0, 32'h0000_0C04, 32'h0000_3010, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick(); check_all("stall");
        end
        set_ctl(1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        tick(); check_all("seq2");
        tick(); check_all("seq3");
        tick(); check_all("seq4");

        // Backward branch below IM base, then not-taken back into range.
        set_ctl(1'b1, 2'd1, 1'b1, 32'h0000_FFFE, 32'h0000_3008, 32'h0);
        tick(); check_all("br_taken");
        branch_cond = 1'b0;
        tick(); check_all("br_not_taken");

        set_ctl(1'b1, 2'd2, 1'b0, 32'h0000_0C04, 32'h0000_3010, 32'h0);
        tick(); check_all("jump");
        set_ctl(1'b1, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0000_3021);
        tick(); check_all("jr_misaligned");
        set_ctl(1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        tick(); check_all("seq_from_fault");

        set_ctl(1'b1, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0000_6FFC);
        tick(); check_all("last_word");
        set_ctl(1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        tick(); check_all("past_end");
        set_ctl(1'b1, 2'd3, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC);
        tick(); check_all("top_addr");
        set_ctl(1'b1, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        tick(); check_all("wrap_zero");

        // Reach 3008, then reset asynchronously between edges.
        set_ctl(1'b1, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0000_3008);
        tick(); check_all("pre_async");
        reset = 1'b1;
        #2;
        m_pc = PC_RESET; m_cnt = 32'd0;
        check_all("async_reset");
        reset = 1'b0;

        // Write-through on the word currently being fetched, while stalled.
        set_ctl(1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0);
        im_we = 1'b1; im_waddr = 12'd0; im_wdata = 32'hDEAD_BEEF;
        #1;
        check_all("wr_before");
        tick(); check_all("wr_after");
        im_we = 1'b0;

        for (int i = 0; i < 400; i++) begin
            En          = ($urandom_range(0, 3) != 0);
            npc_sel     = 2'($urandom_range(0, 3));
            branch_cond = 1'($urandom);
            d_pcadd8    = IM_BASE + 32'($urandom_range(0, IM_DEPTH - 1)) * 4 + 8;
            d_instr     = $urandom & 32'hFC00_0000;
            if (npc_sel == 2'd2)
                d_instr = d_instr | (IM_BASE / 4 + 32'($urandom_range(0, IM_DEPTH - 1)));
            else
                d_instr = d_instr | 32'(16'(int'($urandom_range(0, 127)) - 64));
            d_rs = ($urandom_range(0, 3) != 0)
                   ? IM_BASE + 32'($urandom_range(0, IM_DEPTH - 1)) * 4 : $urandom;
            im_we    = ($urandom_range(0, 4) == 0);
            im_waddr = 12'($urandom);
            im_wdata = $urandom;
            reset    = ($urandom_range(0, 49) == 0);
            tick();
            check_all("rand");
        end
        reset = 1'b0;
        im_we = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
